mixed_precision_csr: RTL and testbench

Holds the mixed-precision state of the core: the cycle counter CSR (0x00D), the format CSR (0x00C) and the skip-size CSR (0x00E). It feeds `current_cycle_i`, `ivec_fmt_i` and `skip_size_i` of the mixed-precision controller and accepts that controller's next-cycle write-back. It arbitrates that write-back against software CSR accesses from the CS-register file. It also emits a one-cycle wrap pulse the load/store side uses to advance the packed-weight pointer.

---
 rtl/mixed_precision_csr_pkg.sv | 51 +++++
 rtl/mixed_precision_csr_if.sv | 21 ++
 rtl/mixed_precision_csr_alu.sv | 23 ++
 rtl/mixed_precision_csr.sv | 110 +++++++++++
 tb/tb_mixed_precision_csr.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/mixed_precision_csr_pkg.sv
// Shared definitions for the mixed-precision CSR slice: CSR addresses,
// operand formats, and the cycles-per-format decode used by the controller.
package mixed_precision_csr_pkg;

  localparam int unsigned NBITS_MIXED_CYCLES = 3;
  localparam int unsigned NBITS_MAX_KER      = 8;

  localparam logic [11:0] CSR_MPC_FMT   = 12'h00C;
  localparam logic [11:0] CSR_MPC_CYCLE = 12'h00D;
  localparam logic [11:0] CSR_MPC_SKIP  = 12'h00E;

  typedef enum logic [1:0] {
    CSR_OP_NONE  = 2'b00,
    CSR_OP_WRITE = 2'b01,
    CSR_OP_SET   = 2'b10,
    CSR_OP_CLEAR = 2'b11
  } csr_opcode_e;

  // Codes 4'h9..4'hF are illegal and never stored.
  typedef enum logic [3:0] {
    IVEC_FMT_8  = 4'h0,
    IVEC_FMT_4  = 4'h1,
    IVEC_FMT_2  = 4'h2,
    MIXED_2x4   = 4'h3,
    MIXED_2x8   = 4'h4,
    MIXED_2x16  = 4'h5,
    MIXED_4x8   = 4'h6,
    MIXED_4x16  = 4'h7,
    MIXED_8x16  = 4'h8
  } ivec_mode_fmt;

  localparam ivec_mode_fmt MPC_FMT_RESET = IVEC_FMT_8;

  // Number of controller cycles needed per format.
  function automatic logic [3:0] mpc_num_cycles(input ivec_mode_fmt fmt);
    logic [3:0] n;
    case (fmt)
      MIXED_2x4, MIXED_4x8, MIXED_8x16: n = 4'd2;
      MIXED_2x8, MIXED_4x16:            n = 4'd4;
      MIXED_2x16:                       n = 4'd8;
      default:                          n = 4'd1;
    endcase
    return n;
  endfunction

  // A full 32-bit CSR value is a legal format only if it is one of the codes.
  function automatic logic mpc_fmt_legal(input logic [31:0] v);
    return (v[31:4] == '0) && (v[3:0] <= 4'h8);
  endfunction

endpackage

// File: rtl/mixed_precision_csr_if.sv
// Software CSR access bus from the CS-register file into this block.
interface mixed_precision_csr_if;
  import mixed_precision_csr_pkg::*;

  logic        csr_access_i;
  csr_opcode_e csr_op_i;
  logic [11:0] csr_addr_i;
  logic [31:0] csr_wdata_i;
  logic [31:0] csr_rdata_o;

  modport master (
    output csr_access_i, csr_op_i, csr_addr_i, csr_wdata_i,
    input  csr_rdata_o
  );

  modport slave (
    input  csr_access_i, csr_op_i, csr_addr_i, csr_wdata_i,
    output csr_rdata_o
  );

endinterface

// File: rtl/mixed_precision_csr_alu.sv
// Combinational CSR update-value generator (WRITE/SET/CLEAR), one instance
// serves whichever register is addressed.
module mpc_csr_alu
  import mixed_precision_csr_pkg::*;
(
  input  csr_opcode_e op,
  input  logic [31:0] old_val,
  input  logic [31:0] wdata,
  output logic [31:0] new_val
);

  // Apply the CSR operation to the currently stored value.
  always_comb begin
    new_val = old_val;
    case (op)
      CSR_OP_WRITE: new_val = wdata;
      CSR_OP_SET:   new_val = old_val | wdata;
      CSR_OP_CLEAR: new_val = old_val & ~wdata;
      default:      new_val = old_val;
    endcase
  end

endmodule

// File: rtl/mixed_precision_csr.sv
// Mixed-precision CSR state: cycle counter, operand format and skip size,
// arbitrated between software CSR writes and controller write-back.
module mixed_precision_csr
  import mixed_precision_csr_pkg::*;
(
  input  logic                          clk,
  input  logic                          rst_n,
  mixed_precision_csr_if.slave          csr_bus,
  input  logic                          mpc_wcsr_i,
  input  logic [NBITS_MIXED_CYCLES-1:0] mpc_next_cycle_i,
  output logic [NBITS_MIXED_CYCLES-1:0] current_cycle_o,
  output ivec_mode_fmt                  ivec_fmt_o,
  output logic [NBITS_MAX_KER-1:0]      skip_size_o,
  output logic [3:0]                    num_cycles_o,
  output logic                          wrap_o
);

  logic [NBITS_MIXED_CYCLES-1:0] cycle_q, cycle_d;
  ivec_mode_fmt                  fmt_q, fmt_d;
  logic [NBITS_MAX_KER-1:0]      skip_q, skip_d;
  logic                          wrap_q, wrap_d;

  logic [31:0]                   rdata;
  logic [31:0]                   upd_val;
  logic [3:0]                    num_cycles;
  logic [3:0]                    num_cycles_m1;
  logic [NBITS_MIXED_CYCLES-1:0] cycle_mask;
  logic                          sw_we;
  logic                          sw_fmt;
  logic                          sw_cyc;
  logic                          sw_skip;

  assign num_cycles    = mpc_num_cycles(fmt_q);
  assign num_cycles_m1 = num_cycles - 4'd1;
  assign cycle_mask    = num_cycles_m1[NBITS_MIXED_CYCLES-1:0];

  assign sw_we   = csr_bus.csr_access_i && (csr_bus.csr_op_i != CSR_OP_NONE);
  assign sw_fmt  = sw_we && (csr_bus.csr_addr_i == CSR_MPC_FMT);
  assign sw_cyc  = sw_we && (csr_bus.csr_addr_i == CSR_MPC_CYCLE);
  assign sw_skip = sw_we && (csr_bus.csr_addr_i == CSR_MPC_SKIP);

  // Zero-extended readback of the addressed register; doubles as ALU old value.
  always_comb begin
    rdata = '0;
    case (csr_bus.csr_addr_i)
      CSR_MPC_FMT:   rdata = 32'(fmt_q);
      CSR_MPC_CYCLE: rdata = 32'(cycle_q);
      CSR_MPC_SKIP:  rdata = 32'(skip_q);
      default:       rdata = '0;
    endcase
  end

  assign csr_bus.csr_rdata_o = rdata;

  mpc_csr_alu u_alu (
    .op      (csr_bus.csr_op_i),
    .old_val (rdata),
    .wdata   (csr_bus.csr_wdata_i),
    .new_val (upd_val)
  );

  // Next-state: controller write-back first, software writes override it.
  always_comb begin
    cycle_d = cycle_q;
    fmt_d   = fmt_q;
    skip_d  = skip_q;
    wrap_d  = 1'b0;

    if (mpc_wcsr_i && !(sw_fmt || sw_cyc)) begin
      cycle_d = mpc_next_cycle_i & cycle_mask;
      wrap_d  = (cycle_q != '0) && (cycle_d == '0);
    end

    if (sw_cyc) begin
      cycle_d = upd_val[NBITS_MIXED_CYCLES-1:0] & cycle_mask;
    end

    if (sw_fmt && mpc_fmt_legal(upd_val)) begin
      fmt_d   = ivec_mode_fmt'(upd_val[3:0]);
      cycle_d = '0;
    end

    if (sw_skip) begin
      skip_d = (upd_val[NBITS_MAX_KER-1:0] == '0) ? NBITS_MAX_KER'(1)
                                                  : upd_val[NBITS_MAX_KER-1:0];
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_q <= '0;
      fmt_q   <= MPC_FMT_RESET;
      skip_q  <= NBITS_MAX_KER'(1);
      wrap_q  <= 1'b0;
    end else begin
      cycle_q <= cycle_d;
      fmt_q   <= fmt_d;
      skip_q  <= skip_d;
      wrap_q  <= wrap_d;
    end
  end

  assign current_cycle_o = cycle_q;
  assign ivec_fmt_o      = fmt_q;
  assign skip_size_o     = skip_q;
  assign num_cycles_o    = num_cycles;
  assign wrap_o          = wrap_q;

endmodule

// File: tb/tb_mixed_precision_csr.sv
// Scoreboard bench for mixed_precision_csr: stimulus pushes expected values,
// a negedge monitor pops and compares them against the DUT.
module tb_mixed_precision_csr;
  import mixed_precision_csr_pkg::*;

  localparam int K_RDATA = 0;
  localparam int K_CYCLE = 1;
  localparam int K_FMT   = 2;
  localparam int K_SKIP  = 3;
  localparam int K_NUM   = 4;
  localparam int K_WRAP  = 5;

  typedef struct {
    int          kind;
    string       name;
    logic [31:0] exp;
  } sb_entry_t;

  logic                          clk = 1'b0;
  logic                          rst_n = 1'b0;
  logic                          mpc_wcsr = 1'b0;
  logic [NBITS_MIXED_CYCLES-1:0] mpc_next = '0;
  logic [NBITS_MIXED_CYCLES-1:0] current_cycle;
  ivec_mode_fmt                  ivec_fmt;
  logic [NBITS_MAX_KER-1:0]      skip_size;
  logic [3:0]                    num_cycles;
  logic                          wrap;

  sb_entry_t sb[$];
  int checks = 0;
  int errors = 0;

  mixed_precision_csr_if bus ();

  mixed_precision_csr dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .csr_bus          (bus.slave),
    .mpc_wcsr_i       (mpc_wcsr),
    .mpc_next_cycle_i (mpc_next),
    .current_cycle_o  (current_cycle),
    .ivec_fmt_o       (ivec_fmt),
    .skip_size_o      (skip_size),
    .num_cycles_o     (num_cycles),
    .wrap_o           (wrap)
  );

  always #5 clk = ~clk;

  // Monitor: compare every queued expectation against what the DUT shows now.
  always @(negedge clk) begin
    while (sb.size() > 0) begin
      sb_entry_t e;
      logic [31:0] act;
      e = sb.pop_front();
      case (e.kind)
        K_RDATA: act = bus.csr_rdata_o;
        K_CYCLE: act = 32'(current_cycle);
        K_FMT:   act = 32'(ivec_fmt);
        K_SKIP:  act = 32'(skip_size);
        K_NUM:   act = 32'(num_cycles);
        default: act = 32'(wrap);
      endcase
      checks++;
      if (act !== e.exp) begin
        errors++;
        $display("FAIL %s: got %0h expected %0h", e.name, act, e.exp);
      end
    end
  end

  task automatic chk(input int kind, input string name, input logic [31:0] exp);
    sb_entry_t e;
    e.kind = kind;
    e.name = name;
    e.exp  = exp;
    sb.push_back(e);
  endtask

  task automatic idle_bus();
    bus.csr_access_i = 1'b0;
    bus.csr_op_i     = CSR_OP_NONE;
    bus.csr_addr_i   = '0;
    bus.csr_wdata_i  = '0;
    mpc_wcsr         = 1'b0;
    mpc_next         = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    idle_bus();
  endtask

  task automatic drive_csr(input csr_opcode_e op, input logic [11:0] addr,
                           input logic [31:0] data);
    bus.csr_access_i = 1'b1;
    bus.csr_op_i     = op;
    bus.csr_addr_i   = addr;
    bus.csr_wdata_i  = data;
  endtask

  task automatic csr_wr(input csr_opcode_e op, input logic [11:0] addr,
                        input logic [31:0] data);
    drive_csr(op, addr, data);
    tick();
  endtask

  task automatic rd(input logic [11:0] addr, input logic [31:0] exp,
                    input string name);
    drive_csr(CSR_OP_NONE, addr, 32'h0);
    chk(K_RDATA, name, exp);
    tick();
  endtask

  task automatic wcsr(input logic [NBITS_MIXED_CYCLES-1:0] nxt);
    mpc_wcsr = 1'b1;
    mpc_next = nxt;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_bus();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset state
    chk(K_WRAP,  "rst_wrap", 32'd0);
    chk(K_NUM,   "rst_num",  32'd1);
    rd(CSR_MPC_FMT,   32'd0, "rst_rd_fmt");
    rd(CSR_MPC_CYCLE, 32'd0, "rst_rd_cycle");
    rd(CSR_MPC_SKIP,  32'd1, "rst_rd_skip");

    // 2x8: four-cycle format, stepping to a wrap
    csr_wr(CSR_OP_WRITE, CSR_MPC_FMT, 32'(MIXED_2x8));
    chk(K_FMT, "fmt_2x8", 32'h4);
    chk(K_NUM, "num_2x8", 32'd4);
    wcsr(3'd1); chk(K_CYCLE, "step1", 32'd1); chk(K_WRAP, "step1_wrap", 32'd0);
    wcsr(3'd2); chk(K_CYCLE, "step2", 32'd2);
    wcsr(3'd3); chk(K_CYCLE, "step3", 32'd3); chk(K_WRAP, "step3_wrap", 32'd0);
    wcsr(3'd0); chk(K_CYCLE, "step0", 32'd0); chk(K_WRAP, "wrap_pulse", 32'd1);
    tick();     chk(K_WRAP, "wrap_clear", 32'd0);

    // 2x4: software write masked to one bit, back-to-back wraps
    csr_wr(CSR_OP_WRITE, CSR_MPC_FMT, 32'(MIXED_2x4));
    csr_wr(CSR_OP_WRITE, CSR_MPC_CYCLE, 32'd7);
    chk(K_CYCLE, "rw_mask_2x4", 32'd1);
    chk(K_NUM,   "num_2x4",     32'd2);
    chk(K_WRAP,  "sw_no_wrap",  32'd0);
    wcsr(3'd0); chk(K_WRAP, "b2b_wrap_a", 32'd1);
    wcsr(3'd1); chk(K_WRAP, "b2b_gap",    32'd0); chk(K_CYCLE, "b2b_c1", 32'd1);
    wcsr(3'd0); chk(K_WRAP, "b2b_wrap_b", 32'd1);

    // 2x16: CSRRS on the cycle register
    csr_wr(CSR_OP_WRITE, CSR_MPC_FMT, 32'(MIXED_2x16));
    chk(K_NUM, "num_2x16", 32'd8);
    wcsr(3'd3); chk(K_CYCLE, "c3_2x16", 32'd3);
    csr_wr(CSR_OP_SET, CSR_MPC_CYCLE, 32'd4);
    chk(K_CYCLE, "rs_3or4", 32'd7);

    // Same-cycle collisions: software wins
    drive_csr(CSR_OP_WRITE, CSR_MPC_CYCLE, 32'd2);
    mpc_wcsr = 1'b1; mpc_next = 3'd5;
    tick();
    chk(K_CYCLE, "collide_cyc", 32'd2);
    chk(K_WRAP,  "collide_wrap", 32'd0);
    drive_csr(CSR_OP_WRITE, CSR_MPC_FMT, 32'(MIXED_2x16));
    mpc_wcsr = 1'b1; mpc_next = 3'd6;
    tick();
    chk(K_CYCLE, "collide_fmt_cyc", 32'd0);
    chk(K_WRAP,  "collide_fmt_wrap", 32'd0);

    // Format change forces cycle to 0; illegal code ignored
    csr_wr(CSR_OP_WRITE, CSR_MPC_FMT, 32'(MIXED_4x16));
    wcsr(3'd3); chk(K_CYCLE, "c3_4x16", 32'd3);
    csr_wr(CSR_OP_WRITE, CSR_MPC_FMT, 32'(MIXED_8x16));
    chk(K_CYCLE, "fmt_clr_cycle", 32'd0);
    chk(K_NUM,   "num_8x16",      32'd2);
    csr_wr(CSR_OP_WRITE, CSR_MPC_FMT, 32'hF);
    chk(K_FMT, "illegal_fmt", 32'h8);
    rd(CSR_MPC_FMT, 32'h8, "rd_fmt_8x16");
    csr_wr(CSR_OP_CLEAR, CSR_MPC_FMT, 32'h8);
    chk(K_FMT, "clear_fmt", 32'h0);
    chk(K_NUM, "num_nonmixed", 32'd1);
    csr_wr(CSR_OP_WRITE, CSR_MPC_CYCLE, 32'd5);
    chk(K_CYCLE, "nonmixed_cyc0", 32'd0);

    // Skip register and unmapped address
    csr_wr(CSR_OP_WRITE, CSR_MPC_SKIP, 32'd0);
    rd(CSR_MPC_SKIP, 32'd1, "skip_zero");
    csr_wr(CSR_OP_WRITE, CSR_MPC_FMT, 32'(MIXED_2x8));
    drive_csr(CSR_OP_WRITE, CSR_MPC_SKIP, 32'h105);
    mpc_wcsr = 1'b1; mpc_next = 3'd2;
    tick();
    chk(K_SKIP,  "skip5", 32'd5);
    chk(K_CYCLE, "skip_wb_cyc", 32'd2);
    csr_wr(CSR_OP_WRITE, 12'h00F, 32'd3);
    chk(K_SKIP,  "unmapped_skip", 32'd5);
    chk(K_CYCLE, "unmapped_cyc",  32'd2);
    rd(12'h00F, 32'd0, "unmapped_rd");

    // Asynchronous reset mid-cycle with accesses pending
    drive_csr(CSR_OP_WRITE, CSR_MPC_CYCLE, 32'd1);
    mpc_wcsr = 1'b1; mpc_next = 3'd3;
    #2 rst_n = 1'b0;
    chk(K_CYCLE, "arst_cyc",  32'd0);
    chk(K_FMT,   "arst_fmt",  32'd0);
    chk(K_SKIP,  "arst_skip", 32'd1);
    chk(K_WRAP,  "arst_wrap", 32'd0);
    chk(K_NUM,   "arst_num",  32'd1);
    @(posedge clk);
    #1;
    idle_bus();
    rst_n = 1'b1;
    tick();
    rd(CSR_MPC_SKIP, 32'd1, "post_rst_skip");

    tick();
    tick();
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain: got %0d expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
